// File: rtl/screen_mapper.sv
// rtl/screen_mapper.sv - fp16 vertex to screen pixel mapper with clip and output FIFO
// Optional: SCREENMAP_ROUND_EN selects round-half-away conversion instead of truncation.
module screen_mapper #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int COORD_W    = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [15:0]        i_X,
  input  logic [15:0]        i_Y,
  input  logic               i_Exception,
  output logic               o_PixValid,
  input  logic               i_PixReady,
  output logic [COORD_W-1:0] o_PixX,
  output logic [COORD_W-1:0] o_PixY,
  output logic [7:0]         o_DropCount
);

  localparam int SW    = COORD_W + 2;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
`ifdef SCREENMAP_ROUND_EN
  localparam int MIN_E = 14;
`else
  localparam int MIN_E = 15;
`endif
  localparam logic signed [SW-1:0] HALF_W = SW'(WIDTH / 2);
  localparam logic signed [SW-1:0] HALF_H = SW'(HEIGHT / 2);
  localparam logic signed [SW-1:0] W_S    = SW'(WIDTH);
  localparam logic signed [SW-1:0] H_S    = SW'(HEIGHT);

  typedef enum logic [1:0] {IDLE, CONVX, CONVY, PUSH} state_t;

  // Returns {clip, signed integer}; denormals and |v| < 1 (or < 0.5 when rounding) give 0.
  function automatic logic [SW:0] fp16_to_int(input logic [15:0] f);
    int            e;
    int            sh;
    logic [SW-1:0] mag;
    logic [SW-1:0] val;
    logic          clip;
    e    = int'(f[14:10]);
    mag  = '0;
    clip = 1'b0;
    if (e == 31 || e >= 15 + COORD_W) begin
      clip = 1'b1;
    end else if (e >= MIN_E) begin
      mag = SW'({1'b1, f[9:0]});
      if (e <= 25) begin
        sh = 25 - e;
`ifdef SCREENMAP_ROUND_EN
        if (sh > 0) mag = mag + (SW'(1) << (sh - 1));
`endif
        mag = mag >> sh;
      end else begin
        mag = mag << (e - 25);
      end
    end
    val = f[15] ? -mag : mag;
    return {clip, val};
  endfunction

  state_t state_q, state_d;
  logic [15:0]        x_q, y_q;
  logic               exc_q, clipx_q, clipy_q;
  logic [COORD_W-1:0] px_q, py_q;
  logic [7:0]         drop_q;

  logic [2*COORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 push, pop, drop, full;
  logic [SW:0]          conv;
  logic signed [SW-1:0] cval, px_full, py_full;
  logic                 clipx_c, clipy_c;

  // One converter serves both coordinates: X in CONVX, Y in CONVY.
  always_comb begin
    conv    = fp16_to_int((state_q == CONVX) ? x_q : y_q);
    cval    = $signed(conv[SW-1:0]);
    px_full = HALF_W + cval;
    py_full = HALF_H - cval;
    clipx_c = conv[SW] | px_full[SW-1] | (px_full >= W_S);
    clipy_c = conv[SW] | py_full[SW-1] | (py_full >= H_S);
  end

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && i_PixReady;

  always_comb begin
    state_d = state_q;
    o_Ready = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) state_d = CONVX;
      end
      CONVX: state_d = CONVY;
      CONVY: state_d = PUSH;
      PUSH: begin
        if (exc_q || clipx_q || clipy_q) begin
          drop    = 1'b1;
          state_d = IDLE;
        end else if (!full || pop) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      exc_q   <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      clipx_q <= 1'b0;
      clipy_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_Valid) begin
        x_q   <= i_X;
        y_q   <= i_Y;
        exc_q <= i_Exception;
      end
      if (state_q == CONVX) begin
        px_q    <= px_full[COORD_W-1:0];
        clipx_q <= clipx_c;
      end
      if (state_q == CONVY) begin
        py_q    <= py_full[COORD_W-1:0];
        clipy_q <= clipy_c;
      end
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {px_q, py_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_PixValid  = (count_q != '0);
  assign o_PixX      = mem_q[rd_ptr_q][2*COORD_W-1:COORD_W];
  assign o_PixY      = mem_q[rd_ptr_q][COORD_W-1:0];
  assign o_DropCount = drop_q;

endmodule
